// File: rtl/rv32i_datapath_units_if.sv
// Bundle between the rv32i control FSM (master) and the execution datapath (slave).
// Carries register file, PC and ALU traffic.
interface rv32i_datapath_units_if;
    logic        ena;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] pc_old;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] rfile_wr_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        overflow;
    logic        zero;
    logic        equal;

    modport master (
        output ena, pc_ena, pc_next, reg_write, rd, rfile_wr_data, rs1, rs2,
               src_a, src_b, alu_control,
        input  pc, pc_old, reg_data1, reg_data2, alu_result, overflow, zero, equal
    );

    modport slave (
        input  ena, pc_ena, pc_next, reg_write, rd, rfile_wr_data, rs1, rs2,
               src_a, src_b, alu_control,
        output pc, pc_old, reg_data1, reg_data2, alu_result, overflow, zero, equal
    );
endinterface

// File: rtl/rv32i_datapath_units.sv
// rv32i execution datapath: 32x32 register file, PC/PC-old registers and a
// combinational ALU with overflow/zero/equal flags.
module rv32i_datapath_units #(
    parameter logic [31:0] PC_START_ADDRESS = 32'h0
) (
    input logic                  clk,
    input logic                  rst,
    rv32i_datapath_units_if.slave bus
);
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_old_q, pc_old_d;
    logic [31:0] regs_q [32];
    logic        reg_we;

    // ---------------- PC / PC-old ----------------
    always_comb begin
        pc_d     = pc_q;
        pc_old_d = pc_old_q;
        if (bus.ena && bus.pc_ena) begin
            pc_d     = bus.pc_next;
            pc_old_d = pc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so pc_old captures the pre-edge pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_START_ADDRESS;
            pc_old_q <= '0;
        end else begin
            pc_q     <= pc_d;
            pc_old_q <= pc_old_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.pc_old = pc_old_q;

    // ---------------- Register file ----------------
    assign reg_we = bus.ena && bus.reg_write && (bus.rd != 5'd0);

    // NOTE: this array is reset on purpose (architectural zero state), which rules out a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[bus.rd] <= bus.rfile_wr_data;
        end
    end

    // No write bypass: a read of the address being written returns the old value.
    assign bus.reg_data1 = (bus.rs1 == 5'd0) ? 32'h0 : regs_q[bus.rs1];
    assign bus.reg_data2 = (bus.rs2 == 5'd0) ? 32'h0 : regs_q[bus.rs2];

    // ---------------- ALU ----------------
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] result;
    logic        ovf;

    assign shamt = bus.src_b[4:0];
    assign sum   = bus.src_a + bus.src_b;
    assign diff  = bus.src_a - bus.src_b;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.alu_control)
            ALU_AND:  result = bus.src_a & bus.src_b;
            ALU_OR:   result = bus.src_a | bus.src_b;
            ALU_XOR:  result = bus.src_a ^ bus.src_b;
            ALU_SLL:  result = bus.src_a << shamt;
            ALU_SRL:  result = bus.src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(bus.src_a) >>> shamt);
            ALU_ADD: begin
                result = sum;
                ovf    = (bus.src_a[31] == bus.src_b[31]) && (sum[31] != bus.src_a[31]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (bus.src_a[31] != bus.src_b[31]) && (diff[31] != bus.src_a[31]);
            end
            ALU_SLT:  result = {31'b0, $signed(bus.src_a) < $signed(bus.src_b)};
            ALU_SLTU: result = {31'b0, bus.src_a < bus.src_b};
            default:  result = '0;
        endcase
    end

    assign bus.alu_result = result;
    assign bus.overflow   = ovf;
    assign bus.zero       = (result == 32'h0);
    assign bus.equal      = (bus.src_a == bus.src_b);
endmodule

// File: tb/tb_rv32i_datapath_units.sv
// Directed scoreboard bench for rv32i_datapath_units: PC, register file, ALU and reset priority.
module tb_rv32i_datapath_units;
    localparam logic [31:0] START = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;

    rv32i_datapath_units_if bus ();

    rv32i_datapath_units #(.PC_START_ADDRESS(START)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic alu(input string name, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic ov,
                       input logic z, input logic eq);
        @(negedge clk);
        bus.alu_control = ctl;
        bus.src_a       = a;
        bus.src_b       = b;
        push({name, "_result"}, res);
        push({name, "_overflow"}, {31'b0, ov});
        push({name, "_zero"}, {31'b0, z});
        push({name, "_equal"}, {31'b0, eq});
        #1;
        check(bus.alu_result);
        check({31'b0, bus.overflow});
        check({31'b0, bus.zero});
        check({31'b0, bus.equal});
    endtask

    initial begin
        rst               = 1'b1;
        bus.ena           = 1'b1;
        bus.pc_ena        = 1'b0;
        bus.pc_next       = '0;
        bus.reg_write     = 1'b0;
        bus.rd            = '0;
        bus.rfile_wr_data = '0;
        bus.rs1           = 5'd5;
        bus.rs2           = 5'd0;
        bus.src_a         = '0;
        bus.src_b         = '0;
        bus.alu_control   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        push("rst_pc", START);
        push("rst_pc_old", 32'h0);
        push("rst_x5", 32'h0);
        #1;
        check(bus.pc);
        check(bus.pc_old);
        check(bus.reg_data1);

        // PC updates
        @(negedge clk);
        bus.pc_ena  = 1'b1;
        bus.pc_next = 32'h104;
        push("pc_upd1", 32'h104);
        push("pc_old_upd1", START);
        @(posedge clk); #1;
        check(bus.pc);
        check(bus.pc_old);
        @(negedge clk);
        bus.pc_next = 32'h108;
        push("pc_upd2", 32'h108);
        push("pc_old_upd2", 32'h104);
        @(posedge clk); #1;
        check(bus.pc);
        check(bus.pc_old);
        @(negedge clk);
        bus.pc_ena = 1'b0;

        // Register write with no bypass
        bus.reg_write     = 1'b1;
        bus.rd            = 5'd3;
        bus.rfile_wr_data = 32'hDEAD_BEEF;
        bus.rs1           = 5'd3;
        push("x3_same_cycle", 32'h0);
        #1;
        check(bus.reg_data1);
        push("x3_after_write", 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check(bus.reg_data1);

        // Write to x0 is discarded
        @(negedge clk);
        bus.rd            = 5'd0;
        bus.rfile_wr_data = 32'h5;
        bus.rs2           = 5'd0;
        push("x0_write", 32'h0);
        @(posedge clk); #1;
        check(bus.reg_data2);

        // ena=0 freezes register file and PC
        @(negedge clk);
        bus.ena           = 1'b0;
        bus.rd            = 5'd3;
        bus.rfile_wr_data = 32'h1234_5678;
        bus.pc_ena        = 1'b1;
        bus.pc_next       = 32'h200;
        push("x3_frozen", 32'hDEAD_BEEF);
        push("pc_frozen", 32'h108);
        push("pc_old_frozen", 32'h104);
        @(posedge clk); #1;
        check(bus.reg_data1);
        check(bus.pc);
        check(bus.pc_old);
        @(negedge clk);
        bus.ena       = 1'b1;
        bus.pc_ena    = 1'b0;
        bus.reg_write = 1'b0;

        // ALU
        alu("add_ovf",  4'b1000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1'b0);
        alu("sub_eq",   4'b1100, 32'h5,         32'h5,         32'h0,         1'b0, 1'b1, 1'b1);
        alu("add_wrap", 4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b1, 1'b0);
        alu("add_pl",   4'b1000, 32'h3,         32'h4,         32'h7,         1'b0, 1'b0, 1'b0);
        alu("sub_ovf",  4'b1100, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        alu("sub_neg",  4'b1100, 32'h3,         32'h4,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        alu("srl",      4'b0110, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1'b0, 1'b0);
        alu("sra",      4'b0111, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0, 1'b0);
        alu("sll",      4'b0101, 32'h1,         32'h1F,        32'h8000_0000, 1'b0, 1'b0, 1'b0);
        alu("slt",      4'b1101, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0);
        alu("sltu",     4'b1111, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b1, 1'b0);
        alu("and",      4'b0001, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1'b0);
        alu("or",       4'b0010, 32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1'b0, 1'b0);
        alu("xor",      4'b0011, 32'hF0F0,      32'hFF00,      32'h0FF0,      1'b0, 1'b0, 1'b0);
        alu("op0000",   4'b0000, 32'h3,         32'h3,         32'h0,         1'b0, 1'b1, 1'b1);
        alu("op1001",   4'b1001, 32'h7,         32'h2,         32'h0,         1'b0, 1'b1, 1'b0);

        // Reset beats pending write and PC update
        @(negedge clk);
        rst               = 1'b1;
        bus.ena           = 1'b1;
        bus.reg_write     = 1'b1;
        bus.rd            = 5'd7;
        bus.rfile_wr_data = 32'hAAAA_5555;
        bus.pc_ena        = 1'b1;
        bus.pc_next       = 32'h300;
        bus.rs1           = 5'd7;
        bus.rs2           = 5'd3;
        push("rst2_pc", START);
        push("rst2_pc_old", 32'h0);
        push("rst2_x7", 32'h0);
        push("rst2_x3", 32'h0);
        @(posedge clk); #1;
        check(bus.pc);
        check(bus.pc_old);
        check(bus.reg_data1);
        check(bus.reg_data2);

        @(negedge clk);
        rst = 1'b0;
        bus.reg_write = 1'b0;
        bus.pc_ena    = 1'b0;

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
